// File: rtl/el2_pkg.sv
// Shared types and helpers for the decode-stage GPR writeback path.
package el2_pkg;

  localparam int GPR_WB_NPORTS = 2;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } el2_gpr_wb_pkt_t;

  // One-hot decode of a GPR index, used to build the busy scoreboard.
  function automatic logic [31:0] el2_gpr_onehot(input logic [4:0] a);
    el2_gpr_onehot = 32'h0000_0001 << a;
  endfunction

endpackage

// File: rtl/el2_dec_gpr_wb_fifo.sv
// Per-requester writeback FIFO; exposes its head for arbitration and a
// per-entry valid/addr view so the top can build the pending-write scoreboard.
module el2_dec_gpr_wb_fifo
  import el2_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  push,
  input  el2_gpr_wb_pkt_t       push_pkt,
  input  logic                  pop,
  output el2_gpr_wb_pkt_t       head,
  output logic [CW-1:0]         count,
  output logic [DEPTH-1:0]      ent_valid,
  output logic [DEPTH-1:0][4:0] ent_addr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  el2_gpr_wb_pkt_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [PW-1:0]               wr_q, wr_d;
  logic [PW-1:0]               rd_q, rd_d;
  logic [CW-1:0]               cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // Next-state: pop clears first so a simultaneous push into the same slot wins.
  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (pop) begin
      vld_d[rd_q] = 1'b0;
      rd_d        = ptr_inc(rd_q);
    end else begin
      rd_d = rd_q;
    end
    if (push) begin
      mem_d[wr_q] = push_pkt;
      vld_d[wr_q] = 1'b1;
      wr_d        = ptr_inc(wr_q);
    end else begin
      wr_d = wr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mem_q <= {DEPTH{{$bits(el2_gpr_wb_pkt_t){1'b0}}}};
      vld_q <= {DEPTH{1'b0}};
      wr_q  <= {PW{1'b0}};
      rd_q  <= {PW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      mem_q <= mem_d;
      vld_q <= vld_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry address view for the scoreboard.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      ent_addr[j] = mem_q[j].addr;
    end
  end

  assign head      = mem_q[rd_q];
  assign count     = cnt_q;
  assign ent_valid = vld_q;

endmodule

// File: rtl/el2_dec_gpr_wb_arb.sv
// GPR writeback scheduler: buffers NREQ writeback sources and grants up to two
// round-robin heads per cycle onto the register file's two write ports.
module el2_dec_gpr_wb_arb
  import el2_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  scan_mode,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][4:0]  req_addr,
  input  logic [NREQ-1:0][31:0] req_data,
  output logic                  wen0,
  output logic                  wen1,
  output logic [4:0]            waddr0,
  output logic [4:0]            waddr1,
  output logic [31:0]           wd0,
  output logic [31:0]           wd1,
  output logic [31:0]           gpr_busy,
  output logic                  idle
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(NREQ);

  // Only consumed by cell-level flops/clock gates; nothing to do at RTL.
  logic unused_scan_mode;
  assign unused_scan_mode = scan_mode;

  logic [NREQ-1:0]                  push_s, pop_s, head_vld_s, ready_s;
  el2_gpr_wb_pkt_t [NREQ-1:0]       pkt_in_s, head_s;
  logic [NREQ-1:0][CW-1:0]          count_s;
  logic [NREQ-1:0][DEPTH-1:0]       ent_vld_s;
  logic [NREQ-1:0][DEPTH-1:0][4:0]  ent_addr_s;

  logic [GPR_WB_NPORTS-1:0] gnt_vld_s;
  logic [RW-1:0]            gnt0_idx_s, gnt1_idx_s, scan_idx_s;
  logic [RW:0]              scan_sum_s;

  logic [RW-1:0] rr_q, rr_d;
  logic          wen0_q, wen0_d, wen1_q, wen1_d;
  logic [4:0]    waddr0_q, waddr0_d, waddr1_q, waddr1_d;
  logic [31:0]   wd0_q, wd0_d, wd1_q, wd1_d;
  logic [31:0]   busy_s;
  logic          idle_s;

  for (genvar i = 0; i < NREQ; i++) begin : g_fifo
    el2_dec_gpr_wb_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk       (clk),
      .rst_l     (rst_l),
      .push      (push_s[i]),
      .push_pkt  (pkt_in_s[i]),
      .pop       (pop_s[i]),
      .head      (head_s[i]),
      .count     (count_s[i]),
      .ent_valid (ent_vld_s[i]),
      .ent_addr  (ent_addr_s[i])
    );
  end

  // Ready depends on stored count only; x0 writes are absorbed without storage.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      head_vld_s[i]    = (count_s[i] != CW'(0));
      ready_s[i]       = (count_s[i] < CW'(DEPTH));
      push_s[i]        = req_valid[i] & ready_s[i] & (req_addr[i] != 5'd0);
      pkt_in_s[i].addr = req_addr[i];
      pkt_in_s[i].data = req_data[i];
    end
  end

  // Round-robin scan from rr_q; heads matching port 0's address wait a cycle.
  always_comb begin
    gnt_vld_s  = {GPR_WB_NPORTS{1'b0}};
    gnt0_idx_s = {RW{1'b0}};
    gnt1_idx_s = {RW{1'b0}};
    pop_s      = {NREQ{1'b0}};
    scan_sum_s = {(RW+1){1'b0}};
    scan_idx_s = {RW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      scan_sum_s = {1'b0, rr_q} + (RW+1)'(k);
      if (scan_sum_s >= (RW+1)'(NREQ)) begin
        scan_sum_s = scan_sum_s - (RW+1)'(NREQ);
      end else begin
        scan_sum_s = scan_sum_s;
      end
      scan_idx_s = scan_sum_s[RW-1:0];
      if (head_vld_s[scan_idx_s] && !gnt_vld_s[0]) begin
        gnt_vld_s[0]      = 1'b1;
        gnt0_idx_s        = scan_idx_s;
        pop_s[scan_idx_s] = 1'b1;
      end else if (head_vld_s[scan_idx_s] && !gnt_vld_s[1] &&
                   (head_s[scan_idx_s].addr != head_s[gnt0_idx_s].addr)) begin
        gnt_vld_s[1]      = 1'b1;
        gnt1_idx_s        = scan_idx_s;
        pop_s[scan_idx_s] = 1'b1;
      end else begin
        pop_s[scan_idx_s] = 1'b0;
      end
    end
  end

  // Pointer advance and port register loads.
  always_comb begin
    rr_d     = rr_q;
    wen0_d   = gnt_vld_s[0];
    wen1_d   = gnt_vld_s[1];
    waddr0_d = waddr0_q;
    wd0_d    = wd0_q;
    waddr1_d = waddr1_q;
    wd1_d    = wd1_q;
    if (gnt_vld_s[1]) begin
      rr_d = (gnt1_idx_s == RW'(NREQ - 1)) ? {RW{1'b0}} : gnt1_idx_s + RW'(1);
    end else if (gnt_vld_s[0]) begin
      rr_d = (gnt0_idx_s == RW'(NREQ - 1)) ? {RW{1'b0}} : gnt0_idx_s + RW'(1);
    end else begin
      rr_d = rr_q;
    end
    if (gnt_vld_s[0]) begin
      waddr0_d = head_s[gnt0_idx_s].addr;
      wd0_d    = head_s[gnt0_idx_s].data;
    end else begin
      waddr0_d = waddr0_q;
      wd0_d    = wd0_q;
    end
    if (gnt_vld_s[1]) begin
      waddr1_d = head_s[gnt1_idx_s].addr;
      wd1_d    = head_s[gnt1_idx_s].data;
    end else begin
      waddr1_d = waddr1_q;
      wd1_d    = wd1_q;
    end
  end

  // Arbiter pointer and write-port registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rr_q     <= {RW{1'b0}};
      wen0_q   <= 1'b0;
      wen1_q   <= 1'b0;
      waddr0_q <= 5'd0;
      waddr1_q <= 5'd0;
      wd0_q    <= 32'd0;
      wd1_q    <= 32'd0;
    end else begin
      rr_q     <= rr_d;
      wen0_q   <= wen0_d;
      wen1_q   <= wen1_d;
      waddr0_q <= waddr0_d;
      waddr1_q <= waddr1_d;
      wd0_q    <= wd0_d;
      wd1_q    <= wd1_d;
    end
  end

  // Scoreboard: every buffered destination plus whatever is on the ports now.
  always_comb begin
    busy_s = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (ent_vld_s[i][j]) begin
          busy_s = busy_s | el2_gpr_onehot(ent_addr_s[i][j]);
        end else begin
          busy_s = busy_s;
        end
      end
    end
    if (wen0_q) begin
      busy_s = busy_s | el2_gpr_onehot(waddr0_q);
    end else begin
      busy_s = busy_s;
    end
    if (wen1_q) begin
      busy_s = busy_s | el2_gpr_onehot(waddr1_q);
    end else begin
      busy_s = busy_s;
    end
    busy_s[0] = 1'b0;
    idle_s    = ~(|head_vld_s) & ~wen0_q & ~wen1_q;
  end

  assign req_ready = ready_s;
  assign wen0      = wen0_q;
  assign wen1      = wen1_q;
  assign waddr0    = waddr0_q;
  assign waddr1    = waddr1_q;
  assign wd0       = wd0_q;
  assign wd1       = wd1_q;
  assign gpr_busy  = busy_s;
  assign idle      = idle_s;

endmodule
